// File: rtl/biset_arbiter.sv
// Round-robin arbiter granting one of REQUESTERS masters access to a BiSet register-file bus,
// with a bounded wait for bus_ack_i and a one-cycle done_o pulse per completed transaction.
module biset_arbiter #(
  parameter int unsigned REQUESTERS = 2,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [REQUESTERS-1:0]                req_i,
  input  logic [REQUESTERS-1:0]                write_i,
  input  logic [REQUESTERS-1:0][ADDR_W-1:0]    addr_i,
  input  logic [REQUESTERS-1:0][31:0]          wdata_i,
  output logic [REQUESTERS-1:0]                done_o,
  output logic                                 err_o,
  output logic [31:0]                          rdata_o,
  output logic                                 bus_valid_o,
  output logic                                 bus_write_o,
  output logic [ADDR_W-1:0]                    bus_addr_o,
  output logic [31:0]                          bus_wdata_o,
  input  logic                                 bus_ack_i,
  input  logic [31:0]                          bus_rdata_i
);

  localparam int unsigned IdxW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int unsigned SumW = IdxW + 1;
  localparam logic [SumW-1:0] ReqN       = SumW'(REQUESTERS);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(REQUESTERS - 1);
  localparam logic [7:0]      TimeoutVal = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     gnt_q, gnt_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                pick_found;
  logic [IdxW-1:0]     pick_idx;
  logic [SumW-1:0]     rr_sum;
  logic [IdxW-1:0]     rr_cand;

  // gnt_q doubles as the round-robin pointer: search starts one past the last grant.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_sum     = '0;
    rr_cand    = '0;
    for (int unsigned k = 1; k <= REQUESTERS; k++) begin
      rr_sum  = {1'b0, gnt_q} + SumW'(k);
      rr_cand = (rr_sum >= ReqN) ? IdxW'(rr_sum - ReqN) : IdxW'(rr_sum);
      if (!pick_found && req_i[rr_cand]) begin
        pick_found = 1'b1;
        pick_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          write_d = write_i[pick_idx];
          addr_d  = addr_i[pick_idx];
          wdata_d = wdata_i[pick_idx];
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = TimeoutVal;
        state_d = StWait;
      end
      StWait: begin
        // Ack wins even on the cycle the counter has run out.
        if (bus_ack_i) begin
          rdata_d = write_q ? '0 : bus_rdata_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == '0) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      gnt_q   <= LastIdx;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    done_o = '0;
    if (state_q == StResp) begin
      done_o[gnt_q] = 1'b1;
    end
  end

  assign bus_valid_o = (state_q == StIssue) || (state_q == StWait);
  assign bus_write_o = write_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_biset_arbiter.sv
// Bench for biset_arbiter: a cycle-level reference model drives requesters and the bus responder,
// pushes expected completions into a scoreboard, and a negedge monitor pops and compares them.
module tb_biset_arbiter;

  localparam int R  = 3;
  localparam int AW = 16;
  localparam int T  = 3;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [R-1:0]         req_i, write_i;
  logic [R-1:0][AW-1:0] addr_i;
  logic [R-1:0][31:0]   wdata_i;
  logic [R-1:0]         done_o;
  logic                 err_o;
  logic [31:0]          rdata_o;
  logic                 bus_valid_o, bus_write_o;
  logic [AW-1:0]        bus_addr_o;
  logic [31:0]          bus_wdata_o;
  logic                 bus_ack_i;
  logic [31:0]          bus_rdata_i;

  biset_arbiter #(.REQUESTERS(R), .ADDR_W(AW), .TIMEOUT(T)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .write_i(write_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .bus_valid_o(bus_valid_o), .bus_write_o(bus_write_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit err; logic [31:0] rdata; int cyc; } exp_t;
  exp_t sbq[$];
  int   glog[$];
  int   n_checks = 0, n_errors = 0, cyc = 0;

  // Reference model state: one transaction in flight at most.
  bit          busy = 1'b0;
  int          last_g = R - 1;
  int          cur_idx, cur_gcyc, cur_d, done_cyc;
  bit          cur_write;
  logic [AW-1:0] cur_addr;
  logic [31:0] cur_wdata, cur_rdata;
  bit          exp_valid = 1'b0;
  bit          hold_err = 1'b0;
  logic [31:0] hold_rdata = '0;
  int          forced_d = -1;
  bit          forced_rd_en = 1'b0;
  logic [31:0] forced_rd = '0;
  logic [R-1:0] hold_mask = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("bus_valid", 64'(bus_valid_o), 64'(exp_valid));
      if (exp_valid)
        chk("bus_fields", 64'({bus_write_o, bus_addr_o, bus_wdata_o}),
            64'({cur_write, cur_addr, cur_wdata}));
      if (done_o != '0) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", 64'(done_o), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("done_resp", 64'({done_o, err_o, rdata_o}),
              64'({R'(1) << e.idx, e.err, e.rdata}));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          hold_err   = e.err;
          hold_rdata = e.rdata;
        end
      end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_done: requester %0d expected done at cycle %0d, got none by %0d",
                 sbq[0].idx, sbq[0].cyc, cyc);
        void'(sbq.pop_front());
      end
      chk("hold_err_rdata", 64'({err_o, rdata_o}), 64'({hold_err, hold_rdata}));
    end
  end

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic raise(input int idx, input bit wr, input logic [AW-1:0] a,
                       input logic [31:0] wd);
    req_i[idx]   = 1'b1;
    write_i[idx] = wr;
    addr_i[idx]  = a;
    wdata_i[idx] = wd;
  endtask

  // One model cycle: requesters, bus responder, expected bus activity and grant decision.
  task automatic body(input bit rnd);
    int j, g;
    bit just_done, ok;
    just_done = 1'b0;
    if (busy && cyc == done_cyc) begin
      req_i[cur_idx] = 1'b0;
      busy = 1'b0;
      just_done = 1'b1;
    end
    for (int i = 0; i < R; i++) begin
      if (!req_i[i] && !(busy && cur_idx == i) &&
          (hold_mask[i] || (rnd && $urandom_range(3) == 0))) begin
        raise(i, 1'($urandom), AW'($urandom), $urandom);
      end else if (rnd && busy && cur_idx == i) begin
        if ($urandom_range(3) == 0) req_i[i] = 1'b0;
        write_i[i] = 1'($urandom);
        addr_i[i]  = AW'($urandom);
        wdata_i[i] = $urandom;
      end
    end
    bus_ack_i   = 1'b0;
    bus_rdata_i = $urandom;
    if (busy) begin
      j = cyc - cur_gcyc - 2;
      exp_valid = (j >= -1) && (j <= ((cur_d < T) ? cur_d : T));
      if (j >= 0 && j <= T && j == cur_d) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = cur_rdata;
      end else if (!(j >= 0 && j <= T && j < cur_d) && rnd) begin
        bus_ack_i = ($urandom_range(2) == 0);
      end
    end else begin
      exp_valid = 1'b0;
      if (rnd) bus_ack_i = ($urandom_range(2) == 0);
    end
    if (!busy && !just_done && req_i != '0) begin
      g = -1;
      for (int k = 1; k <= R; k++)
        if (g < 0 && req_i[(last_g + k) % R]) g = (last_g + k) % R;
      last_g    = g;
      busy      = 1'b1;
      cur_idx   = g;
      cur_gcyc  = cyc;
      cur_write = write_i[g];
      cur_addr  = addr_i[g];
      cur_wdata = wdata_i[g];
      cur_d     = (forced_d >= 0) ? forced_d : int'($urandom_range(T + 1));
      cur_rdata = forced_rd_en ? forced_rd : $urandom;
      ok        = (cur_d <= T);
      done_cyc  = cyc + 3 + (ok ? cur_d : T);
      sbq.push_back('{idx: g, err: !ok, rdata: (ok && !cur_write) ? cur_rdata : 32'h0,
                      cyc: done_cyc});
      glog.push_back(g);
    end
  endtask

  task automatic step(input bit rnd);
    tick();
    body(rnd);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || req_i != '0) && n < 200) begin
      step(1'b0);
      n++;
    end
    if (busy || req_i != '0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: requests still open at cycle %0d", cyc);
    end
    step(1'b0);
  endtask

  task automatic directed(input int idx, input bit wr, input logic [AW-1:0] a,
                          input logic [31:0] wd, input int d, input logic [31:0] rd);
    forced_d     = d;
    forced_rd_en = 1'b1;
    forced_rd    = rd;
    tick();
    raise(idx, wr, a, wd);
    body(1'b0);
    drain();
    forced_d     = -1;
    forced_rd_en = 1'b0;
  endtask

  initial begin
    int start;
    rst_ni = 1'b0;
    req_i = '0; write_i = '0; addr_i = '0; wdata_i = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    tick();
    tick();
    chk("reset_ctrl", 64'({bus_valid_o, bus_write_o, bus_addr_o, done_o, err_o}), 64'(0));
    chk("reset_data", 64'({bus_wdata_o, rdata_o}), 64'(0));
    tick();
    rst_ni = 1'b1;
    body(1'b0);

    directed(0, 1'b1, 16'h0004, 32'hDEADBEEF, 0, 32'h0);
    directed(1, 1'b0, 16'h0010, 32'h0, 2, 32'h12345678);

    // Two requesters held continuously: grants must alternate.
    start = glog.size();
    hold_mask = R'(3);
    for (int n = 0; n < 200 && glog.size() < start + 4; n++) step(1'b0);
    hold_mask = '0;
    for (int i = 0; i < R; i++) if (!(busy && cur_idx == i)) req_i[i] = 1'b0;
    drain();
    for (int k = 0; k < 4; k++)
      chk("rr_order", 64'(glog.size() > start + k ? glog[start + k] : -1), 64'(k % 2));

    directed(0, 1'b1, 16'h0020, 32'hCAFEF00D, T + 1, 32'h0);
    directed(1, 1'b0, 16'h0024, 32'h0, T + 1, 32'hAAAA5555);
    directed(2, 1'b0, 16'h0030, 32'h0, T, 32'h0BADF00D);

    // Reset while waiting on the bus; afterwards index 0 must win again.
    forced_d = T + 1;
    tick();
    raise(0, 1'b1, 16'h0040, 32'h11111111);
    raise(1, 1'b0, 16'h0050, 32'h0);
    body(1'b0);
    step(1'b0);
    step(1'b0);
    rst_ni = 1'b0;
    #1;
    chk("rst_drop_valid", 64'(bus_valid_o), 64'(0));
    chk("rst_outputs", 64'({done_o, err_o, bus_write_o, bus_addr_o}), 64'(0));
    sbq.delete();
    busy = 1'b0; last_g = R - 1; exp_valid = 1'b0;
    hold_err = 1'b0; hold_rdata = '0; bus_ack_i = 1'b0;
    forced_d = 0;
    start = glog.size();
    tick();
    tick();
    tick();
    rst_ni = 1'b1;
    body(1'b0);
    drain();
    forced_d = -1;
    chk("rst_rr_first", 64'(glog.size() > start ? glog[start] : -1), 64'(0));
    chk("rst_rr_second", 64'(glog.size() > start + 1 ? glog[start + 1] : -1), 64'(1));

    for (int n = 0; n < 3000; n++) step(1'b1);
    drain();
    step(1'b0);
    chk("sb_empty", 64'(sbq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/biset_arbiter.md
BISET_ARBITER -- requirements
Module: BiSetArbiter

Interface
REQ-001 SHALL have parameter REQUESTERS, default 2, meaning number of requester ports (1..8).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning BiSet register address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum wait cycles for bus_ack_i (1..255).
REQ-004 SHALL have clk_i, input, 1, meaning the single clock. All logic is on its rising edge.
REQ-005 SHALL have rst_ni, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have req_i, input, [REQUESTERS], meaning per-requester transaction request, level-held until done_o.
REQ-007 SHALL have write_i, input, [REQUESTERS], meaning 1=write and 0=read, per requester.
REQ-008 SHALL have addr_i, input, [REQUESTERS] x ADDR_W, meaning target register address.
REQ-009 SHALL have wdata_i, input, [REQUESTERS] x 32, meaning write data.
REQ-010 SHALL have done_o, output, [REQUESTERS], meaning one-cycle completion pulse.
REQ-011 SHALL have err_o, output, 1, meaning timeout flag, valid with done_o.
REQ-012 SHALL have rdata_o, output, 32, meaning read data, valid with done_o.
REQ-013 SHALL have bus_valid_o, output, 1, meaning a register-file transaction is active.
REQ-014 SHALL have bus_write_o, output, 1, meaning the transaction is a write.
REQ-015 SHALL have bus_addr_o, output, ADDR_W, meaning the transaction address.
REQ-016 SHALL have bus_wdata_o, output, 32, meaning the transaction write data.
REQ-017 SHALL have bus_ack_i, input, 1, meaning the register file accepted or completed the transaction.
REQ-018 SHALL have bus_rdata_i, input, 32, meaning read data, valid with bus_ack_i.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-020 IDLE: if any req_i is set, the FSM SHALL grant one requester by round-robin, latch its write/addr/wdata, and go to ISSUE next cycle.
REQ-021 Round-robin SHALL search from the index after the last granted one, wrapping at REQUESTERS-1 to 0. After reset, the search SHALL start at index 0.
REQ-022 ISSUE: the FSM SHALL assert bus_valid_o with the latched fields, load the timeout counter with TIMEOUT, and go to WAIT.
REQ-023 WAIT: bus_valid_o SHALL stay asserted with stable fields.
  - If bus_ack_i=1, the FSM SHALL capture bus_rdata_i (reads only), clear the error, and go to RESP.
  - Otherwise the counter SHALL decrement. At 0 without ack, the FSM SHALL set the error and go to RESP.
REQ-024 An ack arriving in the same cycle the counter reaches 0 SHALL count as success.
REQ-025 RESP: bus_valid_o SHALL be 0, and done_o[grant] SHALL pulse for exactly one cycle.
  - err_o SHALL be valid with the pulse.
  - rdata_o SHALL hold the captured value, or 0 on a write or a timeout.
  - The FSM SHALL then return to IDLE.
REQ-026 Latency from IDLE grant to done_o SHALL be 3 cycles with ack on the first WAIT cycle, and TIMEOUT+3 cycles on a timeout.
REQ-027 bus_ack_i outside WAIT SHALL be ignored.
REQ-028 Changes to the granted requester's addr_i/wdata_i/write_i after the grant SHALL NOT affect the transaction in flight.
REQ-029 A req_i dropped after the grant SHALL NOT abort the transaction; done_o SHALL still pulse.
REQ-030 A requester SHALL NOT be granted twice in a row while any other requester has req_i set.
REQ-031 rdata_o and err_o SHALL hold their values until the next RESP.

Reset
REQ-032 While rst_ni=0, the FSM SHALL enter IDLE asynchronously.
  - bus_valid_o, bus_write_o, done_o and err_o SHALL be 0.
  - bus_addr_o, bus_wdata_o and rdata_o SHALL be 0.
  - The round-robin pointer SHALL point so that index 0 has priority.
REQ-033 Reset asserted mid-transaction SHALL drop bus_valid_o immediately, and no done_o SHALL be issued for the aborted request.
REQ-034 After reset release, the first grant SHALL occur no earlier than the first rising edge with rst_ni=1.

Verification
REQ-035 Single write: req_i[0]=1, write=1, addr=0x0004, wdata=0xDEADBEEF, ack on the first WAIT cycle.
  - Required: bus_valid_o for 2 cycles with those fields, done_o[0] 3 cycles after the grant, err_o=0, rdata_o=0.
REQ-036 Read: req_i[1]=1, write=0, addr=0x0010, ack with bus_rdata_i=0x12345678 after 4 cycles.
  - Required: done_o[1], rdata_o=0x12345678, err_o=0.
REQ-037 Contention: req_i[0] and req_i[1] held continuously for 4 transactions.
  - Required: grant order 0,1,0,1, no back-to-back grant to one index.
REQ-038 Timeout: TIMEOUT=3, no ack.
  - Required: done_o pulses 6 cycles after the grant, err_o=1, rdata_o=0.
REQ-039 Late ack: an ack arrives in the same cycle the counter hits 0.
  - Required: err_o=0 and the data is captured.
REQ-040 Reset mid-WAIT: rst_ni=0 during WAIT.
  - Required: bus_valid_o=0 immediately, no done_o.
  - After release, a pending req_i[1] with req_i[0]=1 SHALL grant index 0 first.
